fetch_stage: RTL and testbench
==============================

# fetch_stage

Fetch stage and F/D pipeline latch of the 5-stage pipelined processor. It holds the PC, drives the synchronous instruction-memory address, and captures each fetched instruction with its PC into the F/D latch. It consumes the load-use stall from the hazard detector and the taken-branch/jump redirect from the execute stage. Its `fd_insn` output is the instruction that the decode stage and the hazard detector read.

## Interface
- `PC_W`, default 12: PC width in words; imem depth is 2^PC_W.
- `NOP`, default 32'h0000_0000: bubble instruction, `add $0,$0,$0`.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `stall`, in, 1: load-use hazard from the hazard detector; holds PC and F/D.
- `redirect`, in, 1: taken branch or jump resolved in X.
- `redirect_pc`, in, PC_W: target of the redirect.
- `address_imem`, out, PC_W: imem read address. It is combinational and equals `pc_next`.
- `q_imem`, in, 32: imem data. Sync ROM: the address registered at edge t gives data during cycle t+1.
- `fd_insn`, out, 32: F/D instruction.
- `fd_pc`, out, PC_W: PC of `fd_insn`.
- `fd_pc_plus1`, out, PC_W: `fd_pc + 1`, modulo 2^PC_W.
- `fd_valid`, out, 1: F/D holds a real instruction (0 means bubble).
- `dx_bubble`, out, 1: tells the D/X latch to load NOP this cycle.
- `fetch_count`, out, 32: instructions accepted into F/D; saturating.
- `stall_count`, out, 16: cycles with an effective stall; saturating.

## Operation
- Registers: `pc`, `fd_insn`, `fd_pc`, `fd_valid`, `fetch_count`, `stall_count`.
- During reset the registers hold `pc=0`, `fd_insn=NOP`, `fd_pc=0`, `fd_valid=0`, and both counters are 0.
- `pc_next` selection, highest priority first:
  - `!reset_n` → 0.
  - `redirect` → `redirect_pc`.
  - `stall` → `pc`.
  - otherwise → `pc+1`, wrapping from 2^PC_W−1 to 0.
- `address_imem = pc_next`. The ROM therefore registers the same address as `pc`, and `q_imem` is always the instruction at `pc`.
- F/D update at each edge:
  - redirect: `fd_insn=NOP`, `fd_valid=0`, `fd_pc` unchanged (squash the wrong-path fetch).
  - stall and no redirect: all F/D fields hold.
  - otherwise: `fd_insn=q_imem`, `fd_pc=pc`, `fd_valid=1`.
- `dx_bubble = stall | redirect`. It is combinational. On redirect, the instruction in D is also wrong-path.
- Effective stall = `stall & !redirect`. Redirect wins because the stalled instruction is squashed anyway.
- `fetch_count` increments when F/D loads a valid instruction. `stall_count` increments on each effective-stall cycle. Both saturate at all-ones.

## Timing
- Fetch latency: PC value p reaches `fd_insn` at the edge ending the cycle in which `pc==p`. That is one cycle in F, then visible in D.
- First edge after `reset_n` rises: `pc` becomes 1 and F/D captures imem[0] with `fd_valid=1`. No extra bubble is needed, because address 0 was presented during reset.
- Stall for N consecutive cycles: `pc`, `fd_*` and `address_imem` are frozen for N edges, and `stall_count` rises by N.
- Redirect in cycle t: `pc` = `redirect_pc` after edge t. F/D holds a bubble during t+1. The target instruction is in F/D after edge t+1.
- Redirect and stall in the same cycle: treat as redirect only.
- Back-to-back redirects: each one reloads `pc`, and F/D stays a bubble.
- `reset_n` asserted mid-operation: all registers clear immediately, without waiting for an edge. `address_imem` reads 0 while reset is asserted.
- Other inputs are sampled only at rising edges.

## Structure
- Shared processor package holds:
  - `NOP`;
  - the opcode field position [31:27];
  - the reg-field positions rd[26:22], rs[21:17], rt[16:12].
- Decode and the hazard detector use the same constants.
- One natural sub-module, `pipe_reg`: a width-parameterised register with enable, clear-to-value and async active-low reset. Reuse it for the F/D fields and the PC.
- Counters are inline.

## Test plan
- Reset then free-run with imem[k] = k+0x100: `fd_insn` = 0x100, 0x101, 0x102 on successive edges, `fd_pc` = 0,1,2, `fetch_count` = 3.
- `stall` high for 2 cycles while `pc`=5: `address_imem` holds 5, `fd_pc` holds 4, `stall_count` = 2. Next edge loads imem[5].
- `redirect=1`, `redirect_pc=0x40` at `pc`=8: next cycle `fd_insn=NOP`, `fd_valid=0`, `dx_bubble` was 1. One edge later `fd_pc=0x40`.
- `stall` and `redirect` together: redirect behaviour only, and `stall_count` unchanged.
- `pc` = 2^PC_W−1 free-running: next `pc` = 0, and `fd_pc_plus1` for that instruction is 0.
- `reset_n` pulsed low asynchronously between edges mid-stream: outputs clear immediately to the reset values, and fetch restarts at address 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared processor constants: bubble instruction and instruction field positions.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;  // add $0,$0,$0

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RD_MSB     = 26;
  localparam int RD_LSB     = 22;
  localparam int RS_MSB     = 21;
  localparam int RS_LSB     = 17;
  localparam int RT_MSB     = 16;
  localparam int RT_LSB     = 12;

  function automatic logic [4:0] insn_opcode(input logic [31:0] insn);
    return insn[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_pipe_reg.sv
// Width-parameterised pipeline register: async reset, synchronous clear-to-value, enable.
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] clr_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear takes priority over enable so a squash always lands, even under stall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  q <= RST_VAL;
    else if (clr)  q <= clr_val;
    else if (en)   q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage plus F/D latch: PC sequencing, imem addressing, squash on redirect,
// hold on load-use stall, and saturating fetch/stall counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          PC_W = 12,
  parameter logic [31:0] NOP  = NOP_INSN
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] address_imem,
  input  logic [31:0]     q_imem,
  output logic [31:0]     fd_insn,
  output logic [PC_W-1:0] fd_pc,
  output logic [PC_W-1:0] fd_pc_plus1,
  output logic            fd_valid,
  output logic            dx_bubble,
  output logic [31:0]     fetch_count,
  output logic [15:0]     stall_count
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            stall_eff;
  logic            load;

  // Redirect overrides stall: the stalled instruction is wrong-path anyway.
  assign stall_eff = stall & ~redirect;
  assign load      = ~stall & ~redirect;

  // Next-PC select; presenting it as the imem address keeps q_imem aligned with pc.
  always_comb begin
    pc_next = pc + 1'b1;
    if (!reset_n)      pc_next = '0;
    else if (redirect) pc_next = redirect_pc;
    else if (stall)    pc_next = pc;
  end

  assign address_imem = pc_next;
  assign fd_pc_plus1  = fd_pc + 1'b1;
  assign dx_bubble    = stall | redirect;

  pipe_reg #(.W(PC_W), .RST_VAL('0)) u_pc (
    .clock(clock), .reset_n(reset_n), .en(1'b1), .clr(1'b0),
    .clr_val('0), .d(pc_next), .q(pc)
  );

  pipe_reg #(.W(32), .RST_VAL(NOP)) u_fd_insn (
    .clock(clock), .reset_n(reset_n), .en(~stall), .clr(redirect),
    .clr_val(NOP), .d(q_imem), .q(fd_insn)
  );

  // fd_pc is left alone on a squash; only a real load updates it.
  pipe_reg #(.W(PC_W), .RST_VAL('0)) u_fd_pc (
    .clock(clock), .reset_n(reset_n), .en(load), .clr(1'b0),
    .clr_val('0), .d(pc), .q(fd_pc)
  );

  pipe_reg #(.W(1), .RST_VAL(1'b0)) u_fd_valid (
    .clock(clock), .reset_n(reset_n), .en(~stall), .clr(redirect),
    .clr_val(1'b0), .d(1'b1), .q(fd_valid)
  );

  // Saturating count of instructions accepted into F/D.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                        fetch_count <= '0;
    else if (load && fetch_count != '1)  fetch_count <= fetch_count + 32'd1;
  end

  // Saturating count of effective stall cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                             stall_count <= '0;
    else if (stall_eff && stall_count != '1)  stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int PC_W  = 12;
  localparam int DEPTH = 1 << PC_W;
  localparam logic [31:0] NOP = 32'h0;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            stall = 1'b0;
  logic            redirect = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic [PC_W-1:0] address_imem;
  logic [31:0]     q_imem = '0;
  logic [31:0]     fd_insn;
  logic [PC_W-1:0] fd_pc;
  logic [PC_W-1:0] fd_pc_plus1;
  logic            fd_valid;
  logic            dx_bubble;
  logic [31:0]     fetch_count;
  logic [15:0]     stall_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:DEPTH-1];

  fetch_stage #(.PC_W(PC_W), .NOP(NOP)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .address_imem(address_imem), .q_imem(q_imem),
    .fd_insn(fd_insn), .fd_pc(fd_pc), .fd_pc_plus1(fd_pc_plus1),
    .fd_valid(fd_valid), .dx_bubble(dx_bubble), .fetch_count(fetch_count),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  // synchronous ROM
  always @(posedge clock) q_imem <= mem[address_imem];

  // behavioural model: program counter and F/D contents as plain integers
  int          m_pc = 0;
  logic [31:0] m_insn = 0;
  int          m_fdpc = 0;
  logic        m_valid = 0;
  longint      m_fc = 0;
  int          m_sc = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pc = 0; m_insn = NOP; m_fdpc = 0; m_valid = 0; m_fc = 0; m_sc = 0;
    end else if (redirect) begin
      m_insn = NOP; m_valid = 0; m_pc = int'(redirect_pc);
    end else if (stall) begin
      if (m_sc < 65535) m_sc = m_sc + 1;
    end else begin
      m_insn = mem[m_pc]; m_fdpc = m_pc; m_valid = 1;
      if (m_fc < 64'hFFFF_FFFF) m_fc = m_fc + 1;
      m_pc = (m_pc + 1) % DEPTH;
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // per-cycle comparison against the model
  always @(negedge clock) begin
    int exp_addr;
    #2;
    if (!reset_n)      exp_addr = 0;
    else if (redirect) exp_addr = int'(redirect_pc);
    else if (stall)    exp_addr = m_pc;
    else               exp_addr = (m_pc + 1) % DEPTH;
    check("m_address_imem", 32'(address_imem), 32'(exp_addr));
    check("m_fd_insn", fd_insn, m_insn);
    check("m_fd_pc", 32'(fd_pc), 32'(m_fdpc));
    check("m_fd_pc_plus1", 32'(fd_pc_plus1), 32'((m_fdpc + 1) % DEPTH));
    check("m_fd_valid", 32'(fd_valid), 32'(m_valid));
    check("m_dx_bubble", 32'(dx_bubble), 32'(stall | redirect));
    check("m_fetch_count", fetch_count, 32'(m_fc));
    check("m_stall_count", 32'(stall_count), 32'(m_sc));
  end

  task automatic drive(input logic s, input logic r, input logic [PC_W-1:0] rpc);
    @(negedge clock);
    stall = s; redirect = r; redirect_pc = rpc;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'(k + 32'h100);
    repeat (3) @(negedge clock);
    #1;
    check("rst_fd_insn", fd_insn, NOP);
    check("rst_fd_valid", 32'(fd_valid), 32'd0);
    check("rst_fd_pc", 32'(fd_pc), 32'd0);
    check("rst_addr", 32'(address_imem), 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_stall_count", 32'(stall_count), 32'd0);

    @(negedge clock); reset_n = 1'b1;
    repeat (3) drive(0, 0, 0);
    #1;
    check("run_fd_insn", fd_insn, 32'h102);
    check("run_fd_pc", 32'(fd_pc), 32'd2);
    check("run_fetch_count", fetch_count, 32'd3);

    drive(0, 0, 0);
    drive(1, 0, 0);              // cycle with pc=5, stalled
    #1;
    check("stall_addr", 32'(address_imem), 32'd5);
    check("stall_fd_pc", 32'(fd_pc), 32'd4);
    drive(1, 0, 0);
    drive(0, 0, 0);
    #1;
    check("stall_count2", 32'(stall_count), 32'd2);
    check("stall_fd_pc_held", 32'(fd_pc), 32'd4);
    check("stall_addr_release", 32'(address_imem), 32'd6);
    drive(0, 0, 0);
    #1;
    check("after_stall_insn", fd_insn, 32'h105);

    drive(0, 0, 0);
    drive(0, 1, 12'h040);        // cycle with pc=8, redirect
    #1;
    check("redir_bubble", 32'(dx_bubble), 32'd1);
    check("redir_addr", 32'(address_imem), 32'h40);
    drive(0, 0, 0);
    #1;
    check("redir_fd_insn", fd_insn, NOP);
    check("redir_fd_valid", 32'(fd_valid), 32'd0);
    check("redir_fd_pc_held", 32'(fd_pc), 32'd7);
    drive(0, 0, 0);
    #1;
    check("redir_target_pc", 32'(fd_pc), 32'h40);
    check("redir_target_insn", fd_insn, 32'h140);

    drive(1, 1, 12'h080);        // stall and redirect together
    drive(0, 0, 0);
    #1;
    check("sr_stall_count", 32'(stall_count), 32'd2);
    check("sr_fd_valid", 32'(fd_valid), 32'd0);
    drive(0, 0, 0);
    #1;
    check("sr_fd_pc", 32'(fd_pc), 32'h80);

    drive(0, 1, 12'hFFF);
    drive(0, 0, 0);
    drive(0, 0, 0);
    #1;
    check("wrap_fd_pc", 32'(fd_pc), 32'hFFF);
    check("wrap_plus1", 32'(fd_pc_plus1), 32'd0);
    check("wrap_insn", fd_insn, 32'h10FF);
    check("wrap_addr", 32'(address_imem), 32'd1);
    drive(0, 0, 0);
    #1;
    check("wrap_next_pc", 32'(fd_pc), 32'd0);

    #1 reset_n = 1'b0;
    #1;
    check("arst_fd_valid", 32'(fd_valid), 32'd0);
    check("arst_fd_insn", fd_insn, NOP);
    check("arst_fd_pc", 32'(fd_pc), 32'd0);
    check("arst_fetch_count", fetch_count, 32'd0);
    check("arst_stall_count", 32'(stall_count), 32'd0);
    check("arst_addr", 32'(address_imem), 32'd0);
    @(negedge clock); reset_n = 1'b1;
    drive(0, 0, 0);
    #1;
    check("restart_insn", fd_insn, 32'h100);
    check("restart_fd_pc", 32'(fd_pc), 32'd0);

    // random program and random stall/redirect traffic
    @(negedge clock); reset_n = 1'b0;
    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            PC_W'($urandom_range(0, DEPTH - 1)));
    end
    drive(0, 0, 0);
    @(negedge clock);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
